// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and MDU FSM states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        IDLE,
        MDU_BUSY
    } mdu_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding source select for one execute operand; M result wins over W, x0 never forwards.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              we_m_i,
    input  logic              we_w_i,
    output logic [1:0]        sel_o
);

    logic src_nz;
    assign src_nz = (src_i != '0);

    always_comb begin
        sel_o = FWD_RF;
        if (src_nz && we_m_i && (rd_m_i == src_i)) begin
            sel_o = FWD_M;
        end else if (src_nz && we_w_i && (rd_w_i == src_i)) begin
            sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage pipeline; MDU occupancy FSM built only when
// HAZ_MDU_EN is defined (otherwise mdu_start_E is ignored and no flops exist).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic [REG_AW-1:0] rs1_E,
    input  logic [REG_AW-1:0] rs2_E,
    input  logic [REG_AW-1:0] rd_E,
    input  logic [REG_AW-1:0] rd_M,
    input  logic [REG_AW-1:0] rd_W,
    input  logic              reg_write_M,
    input  logic              reg_write_W,
    input  logic              load_E,
    input  logic              pc_src_E,
    input  logic              mem_req_M,
    input  logic              mem_ready_M,
    input  logic              mdu_start_E,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              mdu_busy
);

    logic       mem_wait;
    logic       lw_stall;
    logic       mdu_stall;
    logic       mdu_busy_int;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    assign mem_wait = mem_req_M & ~mem_ready_M;
    assign lw_stall = load_E & (rd_E != '0) & ((rd_E == rs1_D) | (rd_E == rs2_D));

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .src_i  (rs1_E),
        .rd_m_i (rd_M),
        .rd_w_i (rd_W),
        .we_m_i (reg_write_M),
        .we_w_i (reg_write_W),
        .sel_o  (fwd_a)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .src_i  (rs2_E),
        .rd_m_i (rd_M),
        .rd_w_i (rd_W),
        .we_m_i (reg_write_M),
        .we_w_i (reg_write_W),
        .sel_o  (fwd_b)
    );

`ifdef HAZ_MDU_EN
    localparam int CNT_W = $clog2(MDU_LAT);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter keeps running through memory wait states; only the final release waits.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_stall = 1'b0;
        if (state_q == IDLE) begin
            if (mdu_start_E && !mem_wait) begin
                mdu_stall = 1'b1;
                state_d   = MDU_BUSY;
                cnt_d     = CNT_W'(MDU_LAT - 2);
            end
        end else begin
            if (cnt_q != '0) begin
                mdu_stall = 1'b1;
                cnt_d     = cnt_q - CNT_W'(1);
            end else if (!mem_wait) begin
                state_d = IDLE;
            end
        end
    end

    assign mdu_busy_int = (state_q == MDU_BUSY);
`else
    logic unused_mdu;
    assign unused_mdu   = &{1'b0, clk, mdu_start_E, (MDU_LAT >= 2)};
    assign mdu_stall    = 1'b0;
    assign mdu_busy_int = 1'b0;
`endif

    always_comb begin
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        flushW    = 1'b0;
        mdu_busy  = 1'b0;
        if (!rst) begin
            forwardAE = fwd_a;
            forwardBE = fwd_b;
            mdu_busy  = mdu_busy_int;
            // A pending branch flush is deferred until memory is ready again.
            if (mem_wait) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (mdu_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (lw_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end else if (pc_src_E) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized plus directed bench for hazard_ctrl against a cycle-age reference model;
// follows HAZ_MDU_EN so both builds are checked.
module tb_hazard_ctrl;

    localparam int MDU_LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       reg_write_M, reg_write_W, load_E, pc_src_E;
    logic       mem_req_M, mem_ready_M, mdu_start_E;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, stallE, stallM;
    logic       flushD, flushE, flushM, flushW, mdu_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int age      = 0;   // cycles since the MDU op entered BUSY, 0 when idle

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .MDU_LAT(MDU_LAT)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
        .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
        .load_E(load_E), .pc_src_E(pc_src_E),
        .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M), .mdu_start_E(mdu_start_E),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .mdu_busy(mdu_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (src != 0 && reg_write_M && rd_M == src) return 2'b10;
        if (src != 0 && reg_write_W && rd_W == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clr();
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
        reg_write_M = 0; reg_write_W = 0; load_E = 0; pc_src_E = 0;
        mem_req_M = 0; mem_ready_M = 1; mdu_start_E = 0;
    endtask

    // Called just after a rising edge with inputs applied; checks this cycle, advances model.
    task automatic cycle(input string tag);
        logic       mw, hold, busy;
        logic [3:0] st, fl;
        logic [1:0] fa, fb;
        @(negedge clk);
        mw = mem_req_M & ~mem_ready_M;
`ifdef HAZ_MDU_EN
        hold = (age == 0 && mdu_start_E && !mw) || (age >= 1 && age <= MDU_LAT - 2);
        busy = (age >= 1);
`else
        hold = 1'b0;
        busy = 1'b0;
`endif
        st = 4'b0000;
        fl = 4'b0000;
        fa = ref_fwd(rs1_E);
        fb = ref_fwd(rs2_E);
        if (rst) begin
            fa = 2'b00; fb = 2'b00; busy = 1'b0;
        end else if (mw) begin
            st = 4'b1111; fl = 4'b0001;
        end else if (hold) begin
            st = 4'b1110; fl = 4'b0010;
        end else if (load_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D)) begin
            st = 4'b1100; fl = 4'b0100;
        end else if (pc_src_E) begin
            fl = 4'b1100;
        end
        check({tag, "/fwd"},   32'({forwardAE, forwardBE}), 32'({fa, fb}));
        check({tag, "/stall"}, 32'({stallF, stallD, stallE, stallM}), 32'(st));
        check({tag, "/flush"}, 32'({flushD, flushE, flushM, flushW}), 32'(fl));
        check({tag, "/busy"},  32'(mdu_busy), 32'(busy));
`ifdef HAZ_MDU_EN
        if (rst) age = 0;
        else if (age == 0) age = (mdu_start_E && !mw) ? 1 : 0;
        else if (age <= MDU_LAT - 2) age = age + 1;
        else if (!mw) age = 0;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int kind;
        clr();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rs1_E = 5; rd_M = 5; reg_write_M = 1; load_E = 1; rd_E = 3; rs1_D = 3; mem_req_M = 1;
        mem_ready_M = 0; mdu_start_E = 1;
        cycle("reset");
        cycle("reset2");
        rst = 1'b0;

        clr(); rd_M = 5; reg_write_M = 1; rd_W = 5; reg_write_W = 1; rs1_E = 5;
        cycle("fwd_m_over_w");
        rs1_E = 0; rd_M = 0;
        cycle("fwd_x0");
        rs2_E = 5; rd_M = 3;
        cycle("fwd_w");

        clr(); load_E = 1; rd_E = 7; rs2_D = 7;
        cycle("lw_stall");
        rd_E = 0; rs2_D = 0;
        cycle("lw_x0");

        clr(); pc_src_E = 1;
        cycle("branch");

        clr(); mdu_start_E = 1;
        repeat (MDU_LAT) cycle("mdu");
        mdu_start_E = 0;
        cycle("mdu_done");

        clr(); mem_req_M = 1; mem_ready_M = 0; pc_src_E = 1;
        repeat (3) cycle("mem_wait");
        mem_ready_M = 1;
        cycle("mem_release");

        clr(); mdu_start_E = 1;
        cycle("mdu_rst_a");
        cycle("mdu_rst_b");
        rst = 1'b1;
        cycle("mdu_rst");
        rst = 1'b0; mdu_start_E = 0;
        cycle("mdu_post_rst");

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            rs1_D = 5'($urandom_range(0, 7)); rs2_D = 5'($urandom_range(0, 7));
            rs1_E = 5'($urandom_range(0, 7)); rs2_E = 5'($urandom_range(0, 7));
            rd_E  = 5'($urandom_range(0, 7)); rd_M  = 5'($urandom_range(0, 7));
            rd_W  = 5'($urandom_range(0, 7));
            reg_write_M = 1'($urandom); reg_write_W = 1'($urandom);
            kind = $urandom_range(0, 3);
            load_E   = (kind == 1);
            pc_src_E = (kind == 2);
            mem_req_M   = 1'($urandom);
            mem_ready_M = ($urandom_range(0, 9) < 7);
            mdu_start_E = ($urandom_range(0, 3) == 0);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
